// File: rtl/port_map_mc_pkg.sv
// Shared definitions for the multicast port map: unit geometry, per-source FSM
// states, map-row layout and small bit helpers.
package port_map_mc_pkg;

  localparam int NUM_UNITS         = 16;
  localparam int NUM_BRAMS         = 8;
  localparam int ID_OFFSET_BRAM    = 0;
  localparam int NUM_ELMS          = 8;
  localparam int ID_OFFSET_IFLOGIC = 8;
  localparam int WIDTH_PID         = $clog2(NUM_UNITS);
  localparam int WIDTH_CNT         = $clog2(NUM_UNITS + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  typedef struct packed {
    logic [NUM_UNITS-1:0] dst_mask;
    logic [NUM_UNITS-1:0] cmt_mask;
    logic [WIDTH_CNT-1:0] fanout;
  } row_t;

  // One-hot to index; an all-zero input yields 0.
  function automatic logic [WIDTH_PID-1:0] onehot_enc(input logic [NUM_UNITS-1:0] oh);
    logic [WIDTH_PID-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (oh[i]) idx = idx | WIDTH_PID'(i);
    end
    return idx;
  endfunction

  function automatic logic [WIDTH_CNT-1:0] popcount(input logic [NUM_UNITS-1:0] v);
    logic [WIDTH_CNT-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      cnt = cnt + {{(WIDTH_CNT-1){1'b0}}, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/port_map_mc_if.sv
// Request/response bus between the rename unit (master) and the port map (slave).
interface port_map_mc_if;
  import port_map_mc_pkg::*;

  logic                 I_Req;
  logic [WIDTH_PID-1:0] I_PSrcID;
  logic [WIDTH_PID-1:0] I_PDstID;
  logic                 O_Grant;
  logic                 O_Reject;

  modport master (output I_Req, I_PSrcID, I_PDstID, input O_Grant, O_Reject);
  modport slave  (input I_Req, I_PSrcID, I_PDstID, output O_Grant, O_Reject);
endinterface

// File: rtl/port_map_src_fsm.sv
// One source row of the port map: destination/commit masks, fanout and the
// IDLE/ACTIVE/WAIT_ACK release FSM. Ack watchdog built with PORT_MAP_MC_TIMEOUT_EN.
module port_map_src_fsm
  import port_map_mc_pkg::*;
#(
  parameter int MAX_FANOUT  = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 grant,
  input  logic [WIDTH_PID-1:0] grant_dst,
  input  logic [NUM_UNITS-1:0] commit,
  input  logic                 ack,
  output logic [NUM_UNITS-1:0] dst_mask,
  output logic                 can_map,
  output logic                 release_req,
  output logic                 timeout
);

  localparam logic [WIDTH_CNT-1:0] FanoutMax = WIDTH_CNT'(MAX_FANOUT);

  if (MAX_FANOUT < 1 || MAX_FANOUT > NUM_UNITS) begin : g_bad_fanout
    $error("port_map_src_fsm: MAX_FANOUT must be within 1..NUM_UNITS");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("port_map_src_fsm: TIMEOUT_CYC must be at least 1");
  end

  state_t               state_q;
  row_t                 row_q;
  logic [NUM_UNITS-1:0] grant_bit;
  logic [NUM_UNITS-1:0] mask_nxt;
  logic [NUM_UNITS-1:0] cmt_nxt;
  logic                 all_cmt;

  always_comb begin
    grant_bit = '0;
    if (grant) grant_bit[grant_dst] = 1'b1;
  end

  // Commits only land on columns already owned; completion is judged on the
  // post-update row so a same-cycle grant keeps the source ACTIVE.
  assign mask_nxt = row_q.dst_mask | grant_bit;
  assign cmt_nxt  = row_q.cmt_mask | (commit & row_q.dst_mask);
  assign all_cmt  = (mask_nxt != '0) && ((cmt_nxt & mask_nxt) == mask_nxt);

  always_ff @(posedge clock) begin
    if (reset || ack) begin
      state_q <= IDLE;
      row_q   <= '0;
    end else begin
      row_q.dst_mask <= mask_nxt;
      row_q.cmt_mask <= cmt_nxt;
      if (grant) row_q.fanout <= row_q.fanout + WIDTH_CNT'(1);
      case (state_q)
        IDLE:    if (grant) state_q <= ACTIVE;
        ACTIVE:  if (all_cmt) state_q <= WAIT_ACK;
        default: state_q <= state_q;
      endcase
    end
  end

  assign dst_mask    = row_q.dst_mask;
  assign can_map     = (state_q != WAIT_ACK) && (row_q.fanout < FanoutMax);
  assign release_req = (state_q == WAIT_ACK);

`ifdef PORT_MAP_MC_TIMEOUT_EN
  localparam int                 TW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]      TLim = TW'(TIMEOUT_CYC);
  logic            [TW-1:0]      wd_q;

  // Saturating watchdog: holds at the limit until the row is released.
  always_ff @(posedge clock) begin
    if (reset || ack || state_q != WAIT_ACK) wd_q <= '0;
    else if (wd_q != TLim)                   wd_q <= wd_q + TW'(1);
  end

  assign timeout = (wd_q == TLim);
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: rtl/port_map_mc.sv
// Multicast port map: one source to up to MAX_FANOUT destinations, with conflict
// rejection, per-source commit/release FSMs and occupancy flags. Optional macro
// PORT_MAP_MC_TIMEOUT_EN enables the per-source ack watchdog on O_Timeout.
module port_map_mc
  import port_map_mc_pkg::*;
#(
  parameter int MAX_FANOUT  = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                           clock,
  input  logic                           reset,
  port_map_mc_if.slave                   req_if,
  input  logic [NUM_UNITS-1:0]           I_Commit,
  output logic [NUM_UNITS-1:0]           O_Commit,
  input  logic [NUM_UNITS-1:0]           I_Ack,
  output logic [NUM_UNITS-1:0]           O_SrcVld,
  output logic [NUM_UNITS-1:0]           O_DstVld,
  output logic [NUM_UNITS*WIDTH_PID-1:0] O_SrcPort,
  output logic [NUM_UNITS*NUM_UNITS-1:0] O_DstMask,
  output logic [WIDTH_CNT-1:0]           O_NumActive,
  output logic                           O_Empty,
  output logic                           O_Full,
  output logic                           O_Empty_BRAM,
  output logic                           O_Full_BRAM,
  output logic                           O_Empty_IFLogic,
  output logic                           O_Full_IFLogic,
  output logic [NUM_UNITS-1:0]           O_Timeout
);

  logic [NUM_UNITS-1:0][NUM_UNITS-1:0] mask;
  logic [NUM_UNITS-1:0]                can_map;
  logic [NUM_UNITS-1:0]                grant_vec;
  logic [NUM_UNITS-1:0]                bram_cols;
  logic [NUM_UNITS-1:0]                elm_cols;
  logic [NUM_UNITS-1:0]                col;
  logic [WIDTH_PID-1:0]                src;
  logic [WIDTH_PID-1:0]                dst;
  logic [WIDTH_CNT-1:0]                cnt_nxt;
  logic                                accept;
  logic                                grant_q;
  logic                                reject_q;

  assign src = req_if.I_PSrcID;
  assign dst = req_if.I_PDstID;

  always_comb begin
    O_DstVld  = '0;
    bram_cols = '0;
    elm_cols  = '0;
    for (int s = 0; s < NUM_UNITS; s++) begin
      O_DstVld = O_DstVld | mask[s];
      O_SrcVld[s] = |mask[s];
      if (s >= ID_OFFSET_BRAM && s < ID_OFFSET_BRAM + NUM_BRAMS)       bram_cols = bram_cols | mask[s];
      if (s >= ID_OFFSET_IFLOGIC && s < ID_OFFSET_IFLOGIC + NUM_ELMS)  elm_cols  = elm_cols | mask[s];
    end
  end

  // A same-cycle ack on the source wins over the request.
  assign accept = (src != dst) && !O_DstVld[dst] && can_map[src] && !I_Ack[src];

  always_comb begin
    grant_vec = '0;
    if (req_if.I_Req && accept) grant_vec[src] = 1'b1;
  end

  for (genvar s = 0; s < NUM_UNITS; s++) begin : g_src
    port_map_src_fsm #(
      .MAX_FANOUT  (MAX_FANOUT),
      .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_src_fsm (
      .clock       (clock),
      .reset       (reset),
      .grant       (grant_vec[s]),
      .grant_dst   (dst),
      .commit      (I_Commit),
      .ack         (I_Ack[s]),
      .dst_mask    (mask[s]),
      .can_map     (can_map[s]),
      .release_req (O_Commit[s]),
      .timeout     (O_Timeout[s])
    );
  end

  assign O_DstMask = mask;

  // Each column has at most one owner, so encoding the column gives its source.
  always_comb begin
    O_SrcPort = '0;
    col       = '0;
    for (int d = 0; d < NUM_UNITS; d++) begin
      for (int s = 0; s < NUM_UNITS; s++) col[s] = mask[s][d];
      O_SrcPort[d*WIDTH_PID +: WIDTH_PID] = onehot_enc(col);
    end
  end

  assign cnt_nxt = popcount(O_DstVld);

  always_ff @(posedge clock) begin
    if (reset) begin
      grant_q         <= 1'b0;
      reject_q        <= 1'b0;
      O_NumActive     <= '0;
      O_Empty         <= 1'b1;
      O_Full          <= 1'b0;
      O_Empty_BRAM    <= 1'b1;
      O_Full_BRAM     <= 1'b0;
      O_Empty_IFLogic <= 1'b1;
      O_Full_IFLogic  <= 1'b0;
    end else begin
      grant_q         <= req_if.I_Req && accept;
      reject_q        <= req_if.I_Req && !accept;
      O_NumActive     <= cnt_nxt;
      O_Empty         <= (cnt_nxt == '0);
      O_Full          <= (cnt_nxt == WIDTH_CNT'(NUM_UNITS));
      O_Empty_BRAM    <= (bram_cols == '0);
      O_Full_BRAM     <= &bram_cols;
      O_Empty_IFLogic <= (elm_cols == '0);
      O_Full_IFLogic  <= &elm_cols;
    end
  end

  assign req_if.O_Grant  = grant_q;
  assign req_if.O_Reject = reject_q;

endmodule

// File: tb/tb_port_map_mc.sv
// Bench for port_map_mc: directed vector table, corner sequences and random
// traffic against an owner-per-destination reference model.
module tb_port_map_mc;

  localparam int N      = 16;
  localparam int MAXF   = 4;
  localparam int TO_CYC = 16;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   I_Commit = '0;
  logic [N-1:0]   I_Ack = '0;
  logic [N-1:0]   O_Commit, O_SrcVld, O_DstVld, O_Timeout;
  logic [N*4-1:0] O_SrcPort;
  logic [N*N-1:0] O_DstMask;
  logic [4:0]     O_NumActive;
  logic O_Empty, O_Full, O_Empty_BRAM, O_Full_BRAM, O_Empty_IFLogic, O_Full_IFLogic;

  port_map_mc_if bus ();

  port_map_mc #(.MAX_FANOUT(MAXF), .TIMEOUT_CYC(TO_CYC)) dut (
    .clock(clock), .reset(reset), .req_if(bus),
    .I_Commit(I_Commit), .O_Commit(O_Commit), .I_Ack(I_Ack),
    .O_SrcVld(O_SrcVld), .O_DstVld(O_DstVld), .O_SrcPort(O_SrcPort), .O_DstMask(O_DstMask),
    .O_NumActive(O_NumActive), .O_Empty(O_Empty), .O_Full(O_Full),
    .O_Empty_BRAM(O_Empty_BRAM), .O_Full_BRAM(O_Full_BRAM),
    .O_Empty_IFLogic(O_Empty_IFLogic), .O_Full_IFLogic(O_Full_IFLogic),
    .O_Timeout(O_Timeout)
  );

  initial forever #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: owner of each destination, its commit flag, per-source
  // "waiting for ack" flag and watchdog count; registered status expectations.
  int src_of [N];
  bit cmtd   [N];
  bit waiting[N];
  int wcnt   [N];
  bit e_grant, e_reject, e_empty, e_full, e_eb, e_fb, e_ei, e_fi;
  int e_num;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      src_of[i] = -1; cmtd[i] = 0; waiting[i] = 0; wcnt[i] = 0;
    end
    e_grant = 0; e_reject = 0; e_num = 0; e_empty = 1; e_full = 0;
    e_eb = 1; e_fb = 0; e_ei = 1; e_fi = 0;
  endtask

  function automatic int fanout_of(input int s);
    int f = 0;
    for (int d = 0; d < N; d++) if (src_of[d] == s) f++;
    return f;
  endfunction

  task automatic model_edge(input bit req, input int src, input int dst,
                            input logic [N-1:0] cmt, input logic [N-1:0] ack);
    logic [N-1:0] bc, ic;
    bit acc;
    int n = 0;
    bc = '0; ic = '0;
    for (int d = 0; d < N; d++) if (src_of[d] >= 0) begin
      n++;
      if (src_of[d] < 8) bc[d] = 1; else ic[d] = 1;
    end
    e_num = n; e_empty = (n == 0); e_full = (n == N);
    e_eb = (bc == 0); e_fb = (bc == '1); e_ei = (ic == 0); e_fi = (ic == '1);
    acc = req && (src != dst) && (src_of[dst] < 0) && !waiting[src]
          && (fanout_of(src) < MAXF) && !ack[src];
    e_grant = acc; e_reject = req && !acc;
    for (int s = 0; s < N; s++) begin
      if (ack[s] || !waiting[s]) wcnt[s] = 0;
      else if (wcnt[s] < TO_CYC) wcnt[s]++;
    end
    for (int d = 0; d < N; d++)
      if (cmt[d] && src_of[d] >= 0) cmtd[d] = 1;
    for (int s = 0; s < N; s++) if (ack[s]) begin
      waiting[s] = 0;
      for (int d = 0; d < N; d++) if (src_of[d] == s) begin src_of[d] = -1; cmtd[d] = 0; end
    end
    if (acc) begin src_of[dst] = src; cmtd[dst] = 0; end
    for (int s = 0; s < N; s++) if (!waiting[s]) begin
      bit any = 0, all = 1;
      for (int d = 0; d < N; d++) if (src_of[d] == s) begin any = 1; if (!cmtd[d]) all = 0; end
      if (any && all) waiting[s] = 1;
    end
  endtask

  task automatic check_all();
    logic [255:0] em;
    logic [63:0]  ep;
    logic [N-1:0] esv, edv, ecm, eto;
    em = '0; ep = '0; esv = '0; edv = '0; ecm = '0; eto = '0;
    for (int d = 0; d < N; d++) if (src_of[d] >= 0) begin
      em[src_of[d]*N + d] = 1'b1;
      ep[d*4 +: 4] = 4'(src_of[d]);
      esv[src_of[d]] = 1'b1;
      edv[d] = 1'b1;
    end
    for (int s = 0; s < N; s++) begin
      ecm[s] = waiting[s];
`ifdef PORT_MAP_MC_TIMEOUT_EN
      eto[s] = (wcnt[s] == TO_CYC);
`endif
    end
    chk("grant", bus.O_Grant, e_grant);
    chk("reject", bus.O_Reject, e_reject);
    chk("dst_mask", O_DstMask, em);
    chk("src_port", O_SrcPort, ep);
    chk("src_vld", O_SrcVld, esv);
    chk("dst_vld", O_DstVld, edv);
    chk("commit_out", O_Commit, ecm);
    chk("timeout", O_Timeout, eto);
    chk("num_active", O_NumActive, e_num);
    chk("empty", O_Empty, e_empty);
    chk("full", O_Full, e_full);
    chk("empty_bram", O_Empty_BRAM, e_eb);
    chk("full_bram", O_Full_BRAM, e_fb);
    chk("empty_iflogic", O_Empty_IFLogic, e_ei);
    chk("full_iflogic", O_Full_IFLogic, e_fi);
  endtask

  task automatic cycle(input bit req, input int src, input int dst,
                       input logic [N-1:0] cmt, input logic [N-1:0] ack);
    bus.I_Req = req; bus.I_PSrcID = 4'(src); bus.I_PDstID = 4'(dst);
    I_Commit = cmt; I_Ack = ack;
    model_edge(req, src, dst, cmt, ack);
    @(posedge clock); #1;
    check_all();
  endtask

  task automatic do_reset();
    bus.I_Req = 0; I_Commit = '0; I_Ack = '0; reset = 1;
    @(posedge clock); #1;
    model_reset();
    reset = 0;
    chk("rst_empty", O_Empty, 1'b1);
    chk("rst_empty_bram", O_Empty_BRAM, 1'b1);
    chk("rst_empty_iflogic", O_Empty_IFLogic, 1'b1);
    chk("rst_dst_mask", O_DstMask, '0);
    chk("rst_commit", O_Commit, '0);
    check_all();
  endtask

  typedef struct {
    bit req; int src; int dst; logic [N-1:0] cmt; logic [N-1:0] ack;
    bit e_g; bit e_r; int e_num; bit e_c3;
  } vec_t;

  vec_t tbl [15];

  initial begin
    logic [15:0] row;
    tbl[0]  = '{1, 3, 5,  16'h0, 16'h0, 1, 0, 0, 0};
    tbl[1]  = '{1, 3, 6,  16'h0, 16'h0, 1, 0, 1, 0};
    tbl[2]  = '{1, 3, 7,  16'h0, 16'h0, 1, 0, 2, 0};
    tbl[3]  = '{1, 4, 5,  16'h0, 16'h0, 0, 1, 3, 0};
    tbl[4]  = '{1, 3, 3,  16'h0, 16'h0, 0, 1, 3, 0};
    tbl[5]  = '{1, 3, 5,  16'h0, 16'h0, 0, 1, 3, 0};
    tbl[6]  = '{1, 2, 8,  16'h0, 16'h0, 1, 0, 3, 0};
    tbl[7]  = '{1, 2, 9,  16'h0, 16'h0, 1, 0, 4, 0};
    tbl[8]  = '{1, 2, 10, 16'h0, 16'h0, 1, 0, 5, 0};
    tbl[9]  = '{1, 2, 11, 16'h0, 16'h0, 1, 0, 6, 0};
    tbl[10] = '{1, 2, 12, 16'h0, 16'h0, 0, 1, 7, 0};
    tbl[11] = '{0, 0, 0,  16'h0060, 16'h0, 0, 0, 7, 0};
    tbl[12] = '{0, 0, 0,  16'h0080, 16'h0, 0, 0, 7, 1};
    tbl[13] = '{0, 0, 0,  16'h0, 16'h000C, 0, 0, 7, 0};
    tbl[14] = '{0, 0, 0,  16'h0, 16'h0, 0, 0, 0, 0};

    bus.I_Req = 0; bus.I_PSrcID = '0; bus.I_PDstID = '0;
    @(posedge clock); #1;
    do_reset();

    for (int i = 0; i < 15; i++) begin
      cycle(tbl[i].req, tbl[i].src, tbl[i].dst, tbl[i].cmt, tbl[i].ack);
      chk($sformatf("tbl%0d_grant", i), bus.O_Grant, tbl[i].e_g);
      chk($sformatf("tbl%0d_reject", i), bus.O_Reject, tbl[i].e_r);
      chk($sformatf("tbl%0d_num", i), O_NumActive, tbl[i].e_num);
      chk($sformatf("tbl%0d_empty", i), O_Empty, tbl[i].e_num == 0);
      chk($sformatf("tbl%0d_commit3", i), O_Commit[3], tbl[i].e_c3);
      if (i == 2 || i == 5) begin
        row = O_DstMask[3*N +: N];
        chk("mcast_row3", row, 16'h00E0);
        chk("mcast_port5", O_SrcPort[5*4 +: 4], 4'd3);
        chk("mcast_port7", O_SrcPort[7*4 +: 4], 4'd3);
      end
      if (i == 10) begin
        row = O_DstMask[2*N +: N];
        chk("fanout_row2", row, 16'h0F00);
      end
    end

`ifdef PORT_MAP_MC_TIMEOUT_EN
    cycle(1, 3, 5, '0, '0);
    cycle(0, 0, 0, 16'h0020, '0);
    chk("to_wait", O_Commit[3], 1'b1);
    for (int k = 1; k <= TO_CYC; k++) begin
      cycle(0, 0, 0, '0, '0);
      if (k == TO_CYC - 1) chk("to_early", O_Timeout[3], 1'b0);
      if (k == TO_CYC)     chk("to_fire", O_Timeout[3], 1'b1);
    end
    cycle(0, 0, 0, '0, 16'h0008);
    chk("to_clear", O_Timeout[3], 1'b0);
`endif

    cycle(1, 3, 5, '0, '0);
    cycle(1, 3, 8, '0, 16'h0008);
    chk("ack_req_reject", bus.O_Reject, 1'b1);
    chk("ack_req_idle", O_SrcVld[3], 1'b0);
    cycle(1, 3, 5, '0, '0);
    cycle(0, 0, 0, 16'h0020, '0);
    cycle(1, 3, 9, '0, '0);
    chk("wait_reject", bus.O_Reject, 1'b1);
    chk("wait_commit", O_Commit[3], 1'b1);
    do_reset();

    // Fill every column: 4->{0..3}, 0->{4..7}, 1->{8..11}, 2->{12..15}.
    for (int d = 0; d < N; d++) cycle(1, (d < 4) ? 4 : (d / 4) - 1, d, '0, '0);
    cycle(1, 5, 0, '0, '0);
    chk("full_reject", bus.O_Reject, 1'b1);
    chk("full_flag", O_Full, 1'b1);
    chk("full_bram_flag", O_Full_BRAM, 1'b1);
    chk("full_ifl_empty", O_Empty_IFLogic, 1'b1);
    cycle(0, 0, 0, '0, '1);
    cycle(0, 0, 0, '0, '0);

    for (int t = 0; t < 800; t++) begin
      int s, d;
      logic [N-1:0] cm, ak;
      s  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 5));
      d  = $urandom_range(0, 15);
      cm = 16'($urandom) & 16'($urandom);
      ak = ($urandom_range(0, 7) == 0) ? (16'h1 << $urandom_range(0, 15)) : 16'h0;
      cycle($urandom_range(0, 9) < 6, s, d, cm, ak);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
